// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the logic-gate response checker.
// Gate indices select the bit of the mismatch mask and the slot of the compare stage.
package gate_chk_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 8;
    localparam int NUM_GATES = 5;

    localparam int GATE_AND  = 0;
    localparam int GATE_OR   = 1;
    localparam int GATE_XOR  = 2;
    localparam int GATE_NAND = 3;
    localparam int GATE_NOR  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } chk_state_e;

endpackage

// File: rtl/gate_ref_model.sv
// Golden reference for the gate block under test: five bitwise results of a and b.
module gate_ref_model #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] exp_and,
    output logic [WIDTH-1:0] exp_or,
    output logic [WIDTH-1:0] exp_xor,
    output logic [WIDTH-1:0] exp_nand,
    output logic [WIDTH-1:0] exp_nor
);

    assign exp_and  = a & b;
    assign exp_or   = a | b;
    assign exp_xor  = a ^ b;
    assign exp_nand = ~(a & b);
    assign exp_nor  = ~(a | b);

endmodule

// File: rtl/gate_resp_checker.sv
// Session-based checker: accepts stimulus/response vectors, compares them one cycle
// later against the reference model and accumulates saturating pass/fail statistics.
module gate_resp_checker
    import gate_chk_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] y1,
    input  logic [WIDTH-1:0] y2,
    input  logic [WIDTH-1:0] y3,
    input  logic [WIDTH-1:0] y4,
    input  logic [WIDTH-1:0] y5,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [4:0]       first_fail_mask
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    chk_state_e state_r;
    chk_state_e state_nxt_s;

    logic                              in_ready_r;
    logic                              done_r;
    logic                              pass_r;
    logic [CNT_W-1:0]                  vec_count_r;
    logic [CNT_W-1:0]                  err_count_r;
    logic [CNT_W-1:0]                  ff_idx_r;
    logic [4:0]                        ff_mask_r;

    logic                              stg_valid_r;
    logic [WIDTH-1:0]                  stg_a_r;
    logic [WIDTH-1:0]                  stg_b_r;
    logic [NUM_GATES-1:0][WIDTH-1:0]   stg_y_r;

    logic [NUM_GATES-1:0][WIDTH-1:0]   in_y_s;
    logic [WIDTH-1:0]                  exp_and_s;
    logic [WIDTH-1:0]                  exp_or_s;
    logic [WIDTH-1:0]                  exp_xor_s;
    logic [WIDTH-1:0]                  exp_nand_s;
    logic [WIDTH-1:0]                  exp_nor_s;
    logic [4:0]                        mask_s;
    logic                              fail_s;
    logic                              accept_s;
    logic                              clear_s;
    logic [CNT_W-1:0]                  vec_nxt_s;
    logic [CNT_W-1:0]                  err_nxt_s;
    logic [CNT_W-1:0]                  ff_idx_nxt_s;
    logic [4:0]                        ff_mask_nxt_s;

    assign in_y_s   = {y5, y4, y3, y2, y1};
    // in_ready_r is only ever high in RUN, so it alone qualifies a transfer
    assign accept_s = in_valid && in_ready_r;
    assign clear_s  = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));

    gate_ref_model #(
        .WIDTH (WIDTH)
    ) u_ref (
        .a        (stg_a_r),
        .b        (stg_b_r),
        .exp_and  (exp_and_s),
        .exp_or   (exp_or_s),
        .exp_xor  (exp_xor_s),
        .exp_nand (exp_nand_s),
        .exp_nor  (exp_nor_s)
    );

    // Per-gate mismatch flags of the vector held in the compare stage
    always_comb begin
        mask_s            = 5'b00000;
        mask_s[GATE_AND]  = (stg_y_r[GATE_AND]  != exp_and_s);
        mask_s[GATE_OR]   = (stg_y_r[GATE_OR]   != exp_or_s);
        mask_s[GATE_XOR]  = (stg_y_r[GATE_XOR]  != exp_xor_s);
        mask_s[GATE_NAND] = (stg_y_r[GATE_NAND] != exp_nand_s);
        mask_s[GATE_NOR]  = (stg_y_r[GATE_NOR]  != exp_nor_s);
        fail_s            = |mask_s;
    end

    // Session FSM next-state
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s && in_last) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: state_nxt_s = ST_DONE;
            ST_DONE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Statistics update from the committed compare result
    always_comb begin
        vec_nxt_s     = vec_count_r;
        err_nxt_s     = err_count_r;
        ff_idx_nxt_s  = ff_idx_r;
        ff_mask_nxt_s = ff_mask_r;
        if (clear_s) begin
            vec_nxt_s     = CNT_ZERO;
            err_nxt_s     = CNT_ZERO;
            ff_idx_nxt_s  = CNT_ZERO;
            ff_mask_nxt_s = 5'b00000;
        end else if (stg_valid_r) begin
            vec_nxt_s = sat_inc(vec_count_r);
            if (fail_s) begin
                err_nxt_s = sat_inc(err_count_r);
                // err_count saturates instead of wrapping, so zero means no earlier failure
                if (err_count_r == CNT_ZERO) begin
                    ff_idx_nxt_s  = vec_count_r;
                    ff_mask_nxt_s = mask_s;
                end else begin
                    ff_idx_nxt_s  = ff_idx_r;
                    ff_mask_nxt_s = ff_mask_r;
                end
            end else begin
                err_nxt_s = err_count_r;
            end
        end else begin
            vec_nxt_s = vec_count_r;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Compare stage: one accepted vector in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid_r <= 1'b0;
            stg_a_r     <= {WIDTH{1'b0}};
            stg_b_r     <= {WIDTH{1'b0}};
            stg_y_r     <= {(NUM_GATES*WIDTH){1'b0}};
        end else begin
            stg_valid_r <= accept_s;
            if (accept_s) begin
                stg_a_r <= a;
                stg_b_r <= b;
                stg_y_r <= in_y_s;
            end
        end
    end

    // Counters and first-failure record
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_count_r <= CNT_ZERO;
            err_count_r <= CNT_ZERO;
            ff_idx_r    <= CNT_ZERO;
            ff_mask_r   <= 5'b00000;
        end else begin
            vec_count_r <= vec_nxt_s;
            err_count_r <= err_nxt_s;
            ff_idx_r    <= ff_idx_nxt_s;
            ff_mask_r   <= ff_mask_nxt_s;
        end
    end

    // Handshake and status flags, registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
        end else begin
            in_ready_r <= (state_nxt_s == ST_RUN);
            done_r     <= (state_nxt_s == ST_DONE);
            pass_r     <= (state_nxt_s == ST_DONE) && (err_nxt_s == CNT_ZERO);
        end
    end

    assign in_ready        = in_ready_r;
    assign done            = done_r;
    assign pass            = pass_r;
    assign vec_count       = vec_count_r;
    assign err_count       = err_count_r;
    assign first_fail_idx  = ff_idx_r;
    assign first_fail_mask = ff_mask_r;

endmodule

// File: tb/tb_gate_resp_checker.sv
// Directed bench for gate_resp_checker: a default instance plus a CNT_W=2 instance
// sharing the same stimulus, with hand-computed expectations.
module tb_gate_resp_checker;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic       in_last;
    logic [3:0] a, b, y1, y2, y3, y4, y5;

    logic       in_ready, done, pass;
    logic [7:0] vec_count, err_count, first_fail_idx;
    logic [4:0] first_fail_mask;

    logic       s_in_ready, s_done, s_pass;
    logic [1:0] s_vec_count, s_err_count, s_first_fail_idx;
    logic [4:0] s_first_fail_mask;

    int checks = 0;
    int errors = 0;

    // Hand-computed correct responses: {a, b, and, or, xor, nand, nor}
    logic [3:0] tv [5][7] = '{
        '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b1111},
        '{4'b0001, 4'b0011, 4'b0001, 4'b0011, 4'b0010, 4'b1110, 4'b1100},
        '{4'b0101, 4'b1010, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b0000},
        '{4'b1100, 4'b1010, 4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001},
        '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000}
    };

    gate_resp_checker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_last(in_last), .a(a), .b(b),
        .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5),
        .done(done), .pass(pass), .vec_count(vec_count), .err_count(err_count),
        .first_fail_idx(first_fail_idx), .first_fail_mask(first_fail_mask)
    );

    gate_resp_checker #(.WIDTH(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(s_in_ready), .in_last(in_last), .a(a), .b(b),
        .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5),
        .done(s_done), .pass(s_pass), .vec_count(s_vec_count), .err_count(s_err_count),
        .first_fail_idx(s_first_fail_idx), .first_fail_mask(s_first_fail_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic put_vec(input logic [3:0] av, bv, v1, v2, v3, v4, v5, input logic last);
        in_valid = 1'b1;
        in_last  = last;
        a = av; b = bv; y1 = v1; y2 = v2; y3 = v3; y4 = v4; y5 = v5;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic put_good(input int i, input logic last);
        put_vec(tv[i][0], tv[i][1], tv[i][2], tv[i][3], tv[i][4], tv[i][5], tv[i][6], last);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0b exp 0", in_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %0b exp 0", done); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL rst_pass got %0b exp 0", pass); end
        checks++; if (vec_count !== 8'd0) begin errors++; $display("FAIL rst_vec got %0d exp 0", vec_count); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rst_err got %0d exp 0", err_count); end
        checks++; if (first_fail_idx !== 8'd0) begin errors++; $display("FAIL rst_idx got %0d exp 0", first_fail_idx); end
        checks++; if (first_fail_mask !== 5'd0) begin errors++; $display("FAIL rst_mask got %b exp 00000", first_fail_mask); end
        rst_n = 1'b1;
        tick();
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_in_ready got %0b exp 0", in_ready); end
    endtask

    task automatic test_correct();
        pulse_start();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL run_in_ready got %0b exp 1", in_ready); end
        put_good(0, 1'b0);
        checks++; if (vec_count !== 8'd0) begin errors++; $display("FAIL lat_vec0 got %0d exp 0", vec_count); end
        put_good(1, 1'b0);
        checks++; if (vec_count !== 8'd1) begin errors++; $display("FAIL lat_vec1 got %0d exp 1", vec_count); end
        put_good(2, 1'b0);
        put_good(3, 1'b0);
        put_good(4, 1'b1);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL drain_in_ready got %0b exp 0", in_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL drain_done got %0b exp 0", done); end
        checks++; if (vec_count !== 8'd4) begin errors++; $display("FAIL drain_vec got %0d exp 4", vec_count); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ok_done got %0b exp 1", done); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL ok_pass got %0b exp 1", pass); end
        checks++; if (vec_count !== 8'd5) begin errors++; $display("FAIL ok_vec got %0d exp 5", vec_count); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL ok_err got %0d exp 0", err_count); end
        checks++; if (first_fail_idx !== 8'd0) begin errors++; $display("FAIL ok_idx got %0d exp 0", first_fail_idx); end
        checks++; if (first_fail_mask !== 5'd0) begin errors++; $display("FAIL ok_mask got %b exp 00000", first_fail_mask); end
        tick();
        checks++; if (done !== 1'b1 || vec_count !== 8'd5) begin errors++; $display("FAIL ok_hold got done=%0b vec=%0d exp done=1 vec=5", done, vec_count); end
    endtask

    task automatic test_single_fault();
        pulse_start();
        checks++; if (done !== 1'b0 || vec_count !== 8'd0) begin errors++; $display("FAIL sf_clear got done=%0b vec=%0d exp done=0 vec=0", done, vec_count); end
        put_good(0, 1'b0);
        put_good(1, 1'b0);
        put_vec(4'b0101, 4'b1010, 4'b0000, 4'b1111, 4'b1110, 4'b1111, 4'b0000, 1'b0);
        put_good(3, 1'b0);
        put_good(4, 1'b1);
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL sf_done got %0b exp 1", done); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL sf_pass got %0b exp 0", pass); end
        checks++; if (vec_count !== 8'd5) begin errors++; $display("FAIL sf_vec got %0d exp 5", vec_count); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL sf_err got %0d exp 1", err_count); end
        checks++; if (first_fail_idx !== 8'd2) begin errors++; $display("FAIL sf_idx got %0d exp 2", first_fail_idx); end
        checks++; if (first_fail_mask !== 5'b00100) begin errors++; $display("FAIL sf_mask got %b exp 00100", first_fail_mask); end
    endtask

    task automatic test_multi_fault();
        pulse_start();
        put_good(0, 1'b0);
        // y4 and y5 wrong, then y1 wrong on the next vector
        put_vec(4'b0001, 4'b0011, 4'b0001, 4'b0011, 4'b0010, 4'b0000, 4'b0000, 1'b0);
        put_vec(4'b0101, 4'b1010, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 1'b0);
        put_good(3, 1'b1);
        tick();
        checks++; if (vec_count !== 8'd4) begin errors++; $display("FAIL mf_vec got %0d exp 4", vec_count); end
        checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL mf_err got %0d exp 2", err_count); end
        checks++; if (first_fail_idx !== 8'd1) begin errors++; $display("FAIL mf_idx got %0d exp 1", first_fail_idx); end
        checks++; if (first_fail_mask !== 5'b11000) begin errors++; $display("FAIL mf_mask got %b exp 11000", first_fail_mask); end
        checks++; if (pass !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL mf_status got done=%0b pass=%0b exp done=1 pass=0", done, pass); end
    endtask

    task automatic test_saturation();
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            put_vec(4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b1111, (i == 5));
        end
        tick();
        checks++; if (s_vec_count !== 2'd3) begin errors++; $display("FAIL sat_vec got %0d exp 3", s_vec_count); end
        checks++; if (s_err_count !== 2'd3) begin errors++; $display("FAIL sat_err got %0d exp 3", s_err_count); end
        checks++; if (s_first_fail_idx !== 2'd0 || s_first_fail_mask !== 5'b00001) begin errors++; $display("FAIL sat_first got idx=%0d mask=%b exp idx=0 mask=00001", s_first_fail_idx, s_first_fail_mask); end
        checks++; if (s_done !== 1'b1 || s_pass !== 1'b0) begin errors++; $display("FAIL sat_status got done=%0b pass=%0b exp done=1 pass=0", s_done, s_pass); end
        checks++; if (vec_count !== 8'd6 || err_count !== 8'd6) begin errors++; $display("FAIL wide_cnt got vec=%0d err=%0d exp vec=6 err=6", vec_count, err_count); end
    endtask

    task automatic test_restart();
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        checks++; if (vec_count !== 8'd6) begin errors++; $display("FAIL done_ignore_valid got %0d exp 6", vec_count); end
        pulse_start();
        checks++; if (in_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL rs_state got rdy=%0b done=%0b exp rdy=1 done=0", in_ready, done); end
        checks++; if (vec_count !== 8'd0 || err_count !== 8'd0) begin errors++; $display("FAIL rs_cnt got vec=%0d err=%0d exp 0 0", vec_count, err_count); end
        checks++; if (first_fail_idx !== 8'd0 || first_fail_mask !== 5'd0) begin errors++; $display("FAIL rs_first got idx=%0d mask=%b exp 0 00000", first_fail_idx, first_fail_mask); end
        put_good(3, 1'b1);
        tick();
        checks++; if (vec_count !== 8'd1) begin errors++; $display("FAIL rs_vec got %0d exp 1", vec_count); end
        checks++; if (done !== 1'b1 || pass !== 1'b1) begin errors++; $display("FAIL rs_status got done=%0b pass=%0b exp 1 1", done, pass); end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        put_good(0, 1'b0);
        put_good(1, 1'b0);
        tick();
        checks++; if (vec_count !== 8'd2) begin errors++; $display("FAIL mid_vec got %0d exp 2", vec_count); end
        pulse_start();
        tick();
        checks++; if (vec_count !== 8'd2 || in_ready !== 1'b1) begin errors++; $display("FAIL run_start_ignored got vec=%0d rdy=%0b exp 2 1", vec_count, in_ready); end
        put_vec(4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++; if (vec_count !== 8'd0 || err_count !== 8'd0 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst got vec=%0d err=%0d rdy=%0b exp 0 0 0", vec_count, err_count, in_ready); end
        checks++; if (done !== 1'b0 || pass !== 1'b0 || first_fail_mask !== 5'd0 || first_fail_idx !== 8'd0) begin errors++; $display("FAIL mid_rst_flags got done=%0b pass=%0b mask=%b idx=%0d exp all 0", done, pass, first_fail_mask, first_fail_idx); end
        rst_n = 1'b1;
        tick();
        in_valid = 1'b1;
        a = 4'b0000; y1 = 4'b1111;
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        checks++; if (vec_count !== 8'd0 || err_count !== 8'd0 || in_ready !== 1'b0) begin errors++; $display("FAIL idle_ignore got vec=%0d err=%0d rdy=%0b exp 0 0 0", vec_count, err_count, in_ready); end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        a = 4'b0000; b = 4'b0000; y1 = 4'b0000; y2 = 4'b0000;
        y3 = 4'b0000; y4 = 4'b0000; y5 = 4'b0000;
        test_reset();
        test_correct();
        test_single_fault();
        test_multi_fault();
        test_saturation();
        test_restart();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_resp_checker.md
GATE_RESP_CHECKER -- requirements
Module: gate_resp_checker

Interface
REQ-001 Parameter WIDTH, default 4: bit width of operands a, b and of each gate result.
REQ-002 Parameter CNT_W, default 8: width of the vector and error counters.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset; assertion takes effect immediately, deassertion is sampled on clk.
REQ-005 start  input  1  single-cycle request to begin a check session.
REQ-006 in_valid  input  1  the vector on a, b, y1..y5 is valid this cycle.
REQ-007 in_ready  output  1  checker accepts a vector this cycle; transfer occurs when in_valid && in_ready.
REQ-008 in_last  input  1  qualifies the accepted vector as the final one of the session.
REQ-009 a, b  input  WIDTH  operands applied to the gate block under test.
REQ-010 y1, y2, y3, y4, y5  input  WIDTH each  observed AND, OR, XOR, NAND, NOR results.
REQ-011 done  output  1  session complete; results are stable.
REQ-012 pass  output  1  high with done when err_count == 0.
REQ-013 vec_count  output  CNT_W  vectors checked this session.
REQ-014 err_count  output  CNT_W  vectors with at least one mismatching output.
REQ-015 first_fail_idx  output  CNT_W  vec_count value of the first failing vector.
REQ-016 first_fail_mask  output  5  per-gate mismatch flags of the first failing vector; bit0 = y1 ... bit4 = y5.

Function
REQ-017 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE.
REQ-018 IDLE: in_ready = 0; start moves the FSM to RUN and clears all counters and first-fail fields.
REQ-019 RUN: in_ready = 1; an accepted vector is registered into a single compare stage.
REQ-020 Accepting a vector with in_last = 1 SHALL move the FSM to DRAIN; in_ready is 0 from the following cycle.
REQ-021 DRAIN SHALL last exactly one cycle, until the final compare result is committed, then move to DONE.
REQ-022 DONE: done = 1 and pass = (err_count == 0); outputs hold until start is asserted.
REQ-023 start asserted in DONE SHALL behave exactly as start asserted in IDLE.
REQ-024 start SHALL be ignored in RUN and in DRAIN.
REQ-025 Expected values are a&b, a|b, a^b, ~(a&b) and ~(a|b), computed bitwise over WIDTH bits.
REQ-026 A vector accepted in cycle N SHALL update vec_count, err_count and first_fail_* at the edge ending cycle N+1 (latency 1).
REQ-027 Back-to-back acceptance on every RUN cycle SHALL be supported with no lost vectors.
REQ-028 vec_count SHALL increment once per checked vector.
REQ-029 err_count SHALL increment once per vector with a nonzero mismatch mask, regardless of how many gates failed.
REQ-030 vec_count and err_count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-031 first_fail_idx and first_fail_mask SHALL be written only on the first failure of a session; first_fail_idx = vec_count before increment (0-based).
REQ-032 With no failure in a session, first_fail_idx = 0 and first_fail_mask = 0.
REQ-033 in_valid while in_ready = 0 SHALL be ignored; no counter changes.

Reset
REQ-034 While rst_n = 0: state = IDLE, the compare stage is empty, and in_ready, done, pass, vec_count, err_count, first_fail_idx and first_fail_mask are all 0.
REQ-035 Reset mid-session SHALL discard any in-flight vector; after release the block waits in IDLE for start.

Structure
REQ-036 A shared package gate_chk_pkg SHALL hold the state enum, the default WIDTH and CNT_W, and the gate index constants GATE_AND..GATE_NOR (0..4).
REQ-037 The expected-value computation SHALL live in a combinational sub-module gate_ref_model (inputs a, b; five expected outputs).

Verification
REQ-038 Correct vectors: start, then 5 back-to-back correct vectors with last on the fifth (a/b = 0000/0000, 0001/0011, 0101/1010, 1100/1010, 1111/1111) -> done=1, pass=1, vec_count=5, err_count=0, mask=0.
REQ-039 Single fault: vector 2 (0-based) a=0101, b=1010 with y3=1110 -> err_count=1, first_fail_idx=2, first_fail_mask=00100, pass=0.
REQ-040 Multiple faults: two failing vectors, the first with y4 and y5 wrong -> err_count=2, first_fail_mask=11000, mask and idx from the first failure only.
REQ-041 Saturation: with CNT_W=2, 6 failing vectors -> vec_count=3, err_count=3.
REQ-042 Reset mid-session: rst_n pulsed low in RUN after 2 vectors -> all outputs 0 immediately; start ignored in RUN; in_valid with in_ready=0 causes no change.
REQ-043 Restart: start in DONE -> counters cleared, FSM returns to RUN, and a new 1-vector session reports vec_count=1.
